// File: rtl/tag_ram_pkg.sv
// Shared types for the tag RAM controller: sequencer states and arbiter grant select.
package tag_ram_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

endpackage

// File: rtl/tag_ram_arb.sv
// Two-way grant for the shared tag RAM port: write-priority with a starvation
// counter that hands the port to a waiting read after STARVE_MAX denied cycles.
module tag_ram_arb
    import tag_ram_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic gnt_en,
    input  logic rd_valid,
    input  logic wr_valid,
    output gnt_e gnt
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    always_comb begin
        gnt = GNT_NONE;
        if (gnt_en) begin
            if (rd_valid && (!wr_valid || starve_q == CNT_MAX)) begin
                gnt = GNT_RD;
            end else if (wr_valid) begin
                gnt = GNT_WR;
            end
        end
    end

    // Any RUN cycle with a waiting but unserved read counts, including flush-entry cycles.
    always_comb begin
        starve_d = starve_q;
        if (gnt == GNT_RD) begin
            starve_d = '0;
        end else if (run && rd_valid && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Tag RAM front end: init/flush sweep sequencer plus read/write port sharing
// for one single-port 256x32 tag RAM with one-cycle read latency.
module tag_ram_ctrl
    import tag_ram_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 256,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0,
    parameter int                STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              init_done,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rvalid_q, rvalid_d;
    logic              init_done_q, init_done_d;
    logic              run;
    logic              gnt_en;
    gnt_e              gnt;

    assign run    = (state_q == ST_RUN) && !rst;
    assign gnt_en = run && !flush_req;

    tag_ram_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .gnt_en   (gnt_en),
        .rd_valid (rd_valid),
        .wr_valid (wr_valid),
        .gnt      (gnt)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        ram_cen     = 1'b0;
        ram_wen     = 1'b0;
        ram_a       = ptr_q;
        ram_d       = INIT_VAL;
        rd_ready    = 1'b0;
        wr_ready    = 1'b0;
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                ram_cen = 1'b1;
                ram_wen = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                    if (state_q == ST_INIT) begin
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end
                case (gnt)
                    GNT_RD: begin
                        rd_ready = 1'b1;
                        ram_cen  = 1'b1;
                        ram_a    = rd_addr;
                    end
                    GNT_WR: begin
                        wr_ready = 1'b1;
                        ram_cen  = 1'b1;
                        ram_wen  = 1'b1;
                        ram_a    = wr_addr;
                        ram_d    = wr_data;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_INIT;
        endcase
        // Keep the RAM idle while reset is held, whatever the registered state.
        if (rst) begin
            ram_cen = 1'b0;
            ram_wen = 1'b0;
        end
    end

    assign rvalid_d   = (gnt == GNT_RD);
    assign rd_rvalid  = rvalid_q;
    assign rd_rdata   = ram_q;
    assign init_done  = init_done_q;
    assign flush_busy = rst || (state_q != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            rvalid_q    <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rvalid_q    <= rvalid_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Bench for tag_ram_ctrl: behavioural single-port RAM, vector table for RUN-mode
// traffic, hand sequences for init sweep, starvation, flush and mid-sweep reset.
module tb_tag_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_valid = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_ready;
    logic        rd_rvalid;
    logic [31:0] rd_rdata;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic        init_done;
    logic        ram_cen;
    logic        ram_wen;
    logic [7:0]  ram_a;
    logic [31:0] ram_d;
    logic [31:0] ram_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tag_ram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_rvalid  (rd_rvalid),
        .rd_rdata   (rd_rdata),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .init_done  (init_done),
        .ram_cen    (ram_cen),
        .ram_wen    (ram_wen),
        .ram_a      (ram_a),
        .ram_d      (ram_d),
        .ram_q      (ram_q)
    );

    // Single-port RAM, pre-filled with non-zero junk so the init sweep is observable.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    end
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) mem[ram_a] <= ram_d;
            else         ram_q <= mem[ram_a];
        end
    end

    typedef struct {
        logic        rv;
        logic [7:0]  ra;
        logic        wv;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        e_rr;
        logic        e_wr;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_cen;
        logic        e_wen;
        logic [7:0]  e_a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rv, logic [7:0] ra, logic wv, logic [7:0] wa,
                                logic [31:0] wd, logic e_rr, logic e_wr, logic e_rvalid,
                                logic [31:0] e_rdata, logic e_cen, logic e_wen, logic [7:0] e_a);
        vec_t v;
        v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
        v.e_rr = e_rr; v.e_wr = e_wr; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
        v.e_cen = e_cen; v.e_wen = e_wen; v.e_a = e_a;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, outputs settle 1 time unit later.
    task automatic drive(input logic r, input logic rv, input logic [7:0] ra, input logic wv,
                         input logic [7:0] wa, input logic [31:0] wd, input logic fl);
        @(negedge clk);
        rst = r; rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        flush_req = fl;
        #1;
    endtask

    // Sweep of n cycles with both requesters knocking; flush_req held for the first fl_cycles.
    task automatic sweep(input string name, input int n, input logic exp_done, input int fl_cycles);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b1, 8'(i), 32'hFFFF_FFFF, i < fl_cycles);
            chk({name, "_ctl"}, {27'd0, flush_busy, ram_cen, ram_wen, rd_ready, wr_ready},
                32'b11100);
            chk({name, "_a"}, {24'd0, ram_a}, i);
            chk({name, "_d"}, ram_d, 32'h0);
            chk({name, "_done"}, {31'd0, init_done}, {31'd0, exp_done});
        end
        $display("sweep %s: %0d cycles checked", name, n);
    endtask

    initial begin
        // Reset state
        drive(1'b1, 1'b1, 8'd0, 1'b1, 8'd0, 32'h0, 1'b0);
        chk("rst_busy", {31'd0, flush_busy}, 32'd1);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        chk("rst_ready", {30'd0, rd_ready, wr_ready}, 32'd0);
        chk("rst_ram", {30'd0, ram_cen, ram_wen}, 32'd0);
        chk("rst_rvalid", {31'd0, rd_rvalid}, 32'd0);

        // Initial sweep
        sweep("init", 256, 1'b0, 0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 32'h0, 1'b0);
        chk("init_exit_busy", {31'd0, flush_busy}, 32'd0);
        chk("init_exit_done", {31'd0, init_done}, 32'd1);
        chk("init_exit_cen", {31'd0, ram_cen}, 32'd0);
        chk("init_mem_ff", mem[255], 32'h0);
        chk("init_mem_00", mem[0], 32'h0);

        // RUN-mode traffic table
        vecs.push_back(mk(0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 1, 1, 5));
        vecs.push_back(mk(1, 5, 0, 0, 0,            1, 0, 0, 0, 1, 0, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 1, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h11,       0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h22,       0, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 2, 32'h33,       0, 1, 0, 0, 1, 1, 2));
        vecs.push_back(mk(0, 0, 1, 3, 32'h44,       0, 1, 0, 0, 1, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0,            1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,            1, 0, 1, 32'h11, 1, 0, 1));
        vecs.push_back(mk(1, 2, 0, 0, 0,            1, 0, 1, 32'h22, 1, 0, 2));
        vecs.push_back(mk(1, 3, 0, 0, 0,            1, 0, 1, 32'h33, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 1, 32'h44, 0, 0, 0));
        vecs.push_back(mk(1, 2, 1, 6, 32'h66,       0, 1, 0, 0, 1, 1, 6));
        vecs.push_back(mk(1, 2, 0, 0, 0,            1, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(1, 6, 0, 0, 0,            1, 0, 1, 32'h33, 1, 0, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 1, 32'h66, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0));
        foreach (vecs[k]) begin
            int e0;
            e0 = errors;
            drive(1'b0, vecs[k].rv, vecs[k].ra, vecs[k].wv, vecs[k].wa, vecs[k].wd, 1'b0);
            chk($sformatf("vec%0d_ready", k), {30'd0, rd_ready, wr_ready},
                {30'd0, vecs[k].e_rr, vecs[k].e_wr});
            chk($sformatf("vec%0d_rvalid", k), {31'd0, rd_rvalid}, {31'd0, vecs[k].e_rvalid});
            if (vecs[k].e_rvalid) chk($sformatf("vec%0d_rdata", k), rd_rdata, vecs[k].e_rdata);
            chk($sformatf("vec%0d_ram", k), {22'd0, ram_cen, ram_wen, ram_a},
                {22'd0, vecs[k].e_cen, vecs[k].e_wen, vecs[k].e_a});
            if (vecs[k].wv && vecs[k].e_wr) chk($sformatf("vec%0d_d", k), ram_d, vecs[k].wd);
            $display("vec %0d rv=%0d ra=%0d wv=%0d wa=%0d -> rr=%0d wr=%0d rvalid=%0d rdata=%h %s",
                     k, vecs[k].rv, vecs[k].ra, vecs[k].wv, vecs[k].wa, rd_ready, wr_ready,
                     rd_rvalid, rd_rdata, (errors == e0) ? "ok" : "bad");
        end

        // Starvation: both held -> W W W W R, repeating
        for (int i = 0; i < 10; i++) begin
            logic exp_rd;
            exp_rd = (i % 5) == 4;
            drive(1'b0, 1'b1, 8'd7, 1'b1, 8'd7, 32'h77, 1'b0);
            chk($sformatf("starve%0d", i), {30'd0, rd_ready, wr_ready}, {30'd0, exp_rd, !exp_rd});
            $display("starve cycle %0d rd_ready=%0d wr_ready=%0d", i, rd_ready, wr_ready);
        end

        // Flush: read accepted just before the flush still returns pre-flush data
        drive(1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 32'h1234, 1'b0);
        chk("fl_wr", {31'd0, wr_ready}, 32'd1);
        drive(1'b0, 1'b1, 8'd9, 1'b0, 8'd0, 32'h0, 1'b0);
        chk("fl_rd", {31'd0, rd_ready}, 32'd1);
        drive(1'b0, 1'b1, 8'd9, 1'b1, 8'd9, 32'h0, 1'b1);
        chk("fl_req_nogrant", {29'd0, rd_ready, wr_ready, ram_cen}, 32'd0);
        chk("fl_req_rvalid", {31'd0, rd_rvalid}, 32'd1);
        chk("fl_req_rdata", rd_rdata, 32'h1234);
        $display("flush entry rvalid=%0d rdata=%h", rd_rvalid, rd_rdata);
        sweep("flush", 256, 1'b1, 20);
        drive(1'b0, 1'b1, 8'd9, 1'b0, 8'd0, 32'h0, 1'b0);
        chk("fl_exit_busy", {31'd0, flush_busy}, 32'd0);
        chk("fl_exit_rd", {31'd0, rd_ready}, 32'd1);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 32'h0, 1'b0);
        chk("fl_rd9_rvalid", {31'd0, rd_rvalid}, 32'd1);
        chk("fl_rd9_rdata", rd_rdata, 32'h0);
        $display("post-flush read 9 rvalid=%0d rdata=%h", rd_rvalid, rd_rdata);

        // Reset with a read pending: no grant, no rvalid afterwards
        drive(1'b1, 1'b1, 8'd3, 1'b0, 8'd0, 32'h0, 1'b0);
        chk("rrd_ready", {29'd0, rd_ready, wr_ready, ram_cen}, 32'd0);
        sweep("rst1", 100, 1'b0, 0);
        chk("rrd_rvalid_dropped", {31'd0, rd_rvalid}, 32'd0);
        // Reset at sweep ptr 100
        drive(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 32'h0, 1'b0);
        chk("rst100_busy", {31'd0, flush_busy}, 32'd1);
        chk("rst100_cen", {31'd0, ram_cen}, 32'd0);
        sweep("rst2", 256, 1'b0, 0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 32'h0, 1'b0);
        chk("rst2_exit_done", {31'd0, init_done}, 32'd1);
        chk("rst2_exit_busy", {31'd0, flush_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
